// File: rtl/mem_link_pkg.sv
// Framing constants and FSM encoding shared by both ends of the serial memory link.
package mem_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_ADDR  = 3'd1,
    ST_GET_DATA  = 3'd2,
    ST_MEM_WRITE = 3'd3,
    ST_MEM_READ  = 3'd4,
    ST_CAPTURE   = 3'd5,
    ST_SEND      = 3'd6,
    ST_DONE      = 3'd7
  } link_state_e;

  localparam int         CMD_WRITE_BIT = 7;
  localparam logic [7:0] CMD_RSVD_MASK = 8'h78;
  localparam int         SIZE_LOAD_W   = 3;
  localparam int         MEM_WRITE_W   = 2;

  function automatic logic cmd_is_legal(input logic [7:0] cmd);
    return (cmd & CMD_RSVD_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/uart_mem_server_if.sv
// Byte-wide synchronous memory port between the link server and the data RAM.
interface uart_mem_server_if;
  import mem_link_pkg::*;

  logic [7:0]             mem_addr;
  logic [7:0]             mem_wdata;
  logic [SIZE_LOAD_W-1:0] mem_size;
  logic                   mem_we;
  logic                   mem_re;
  logic [7:0]             mem_rdata;

  modport master (output mem_addr, mem_wdata, mem_size, mem_we, mem_re, input mem_rdata);
  modport slave  (input mem_addr, mem_wdata, mem_size, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/mem_link_timeout.sv
// Inter-byte watchdog: reloads on clear or when idle, expires after TIMEOUT_CYCLES running cycles.
module mem_link_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ZERO = W'(0);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clear_i || !run_i) begin
      cnt_d = LOAD;
    end else if (cnt_q != ZERO) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= LOAD;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = run_i && (cnt_q == ZERO);
endmodule

// File: rtl/uart_sm_rx.sv
// 8N1 UART receiver; byte_end_o pulses one cycle with data_o valid after a good stop bit.
module uart_sm_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic       byte_end_o,
  output logic [7:0] data_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = CW'(0);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    sync_q;
  logic          end_q, end_d;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    end_d   = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = ZERO;
        bit_d = 3'd0;
        st_d  = sync_q[1] ? RX_IDLE : RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d = ZERO;
          st_d  = sync_q[1] ? RX_IDLE : RX_DATA;
        end else begin
          st_d = RX_START;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = ZERO;
          shift_d = {sync_q[1], shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          st_d    = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          st_d = RX_DATA;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = ZERO;
          end_d = sync_q[1];
          st_d  = RX_IDLE;
        end else begin
          st_d = RX_STOP;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= RX_IDLE;
      cnt_q   <= ZERO;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      sync_q  <= 2'b11;
      end_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sync_q  <= {sync_q[0], rx_i};
      end_q   <= end_d;
    end
  end

  assign byte_end_o = end_q;
  assign data_o     = shift_q;
endmodule

// File: rtl/uart_sm_tx.sv
// 8N1 UART transmitter; byte_end_o is high in the final stop-bit cycle.
module uart_sm_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_pulse_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       byte_end_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = CW'(0);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  tx_state_e     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (st_q)
      TX_IDLE: begin
        cnt_d = ZERO;
        bit_d = 3'd0;
        if (send_pulse_i) begin
          shift_d = data_i;
          st_d    = TX_START;
        end else begin
          st_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (cnt_q == LAST) begin
          cnt_d = ZERO;
          st_d  = TX_DATA;
        end else begin
          st_d = TX_START;
        end
      end
      TX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = ZERO;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          st_d    = (bit_q == 3'd7) ? TX_STOP : TX_DATA;
        end else begin
          st_d = TX_DATA;
        end
      end
      TX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = ZERO;
          st_d  = TX_IDLE;
        end else begin
          st_d = TX_STOP;
        end
      end
      default: st_d = TX_IDLE;
    endcase
    // Line level is registered from the next state so tx never glitches.
    case (st_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= TX_IDLE;
      cnt_q   <= ZERO;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o       = tx_q;
  assign byte_end_o = (st_q == TX_STOP) && (cnt_q == LAST);
endmodule

// File: rtl/uart_mem_server.sv
// Memory-side endpoint of the serial link: decodes cmd/addr[/data] frames into
// single-cycle RAM accesses and returns one reply byte for reads.
module uart_mem_server
  import mem_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CLKS_PER_BIT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              tx,
  uart_mem_server_if.master mem,
  output logic              busy,
  output logic              req_done,
  output logic              frame_err
);
  link_state_e            state_q, state_d;
  logic                   rx_byte_end, tx_byte_end, expire, send_pulse;
  logic [7:0]             rx_data;
  logic                   is_write_q;
  logic [7:0]             addr_q, wdata_q, reply_q;
  logic [SIZE_LOAD_W-1:0] size_q;

  uart_sm_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .reset(reset), .rx_i(rx), .byte_end_o(rx_byte_end), .data_o(rx_data)
  );

  uart_sm_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk), .reset(reset), .send_pulse_i(send_pulse), .data_i(reply_q),
    .tx_o(tx), .byte_end_o(tx_byte_end)
  );

  mem_link_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .reset(reset), .clear_i(rx_byte_end),
    .run_i((state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA)), .expire_o(expire)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A byte arriving together with the timeout takes priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = (rx_byte_end && cmd_is_legal(rx_data)) ? ST_GET_ADDR : ST_IDLE;
      ST_GET_ADDR:  state_d = rx_byte_end ? (is_write_q ? ST_GET_DATA : ST_MEM_READ)
                                          : (expire ? ST_IDLE : ST_GET_ADDR);
      ST_GET_DATA:  state_d = rx_byte_end ? ST_MEM_WRITE : (expire ? ST_IDLE : ST_GET_DATA);
      ST_MEM_WRITE: state_d = ST_DONE;
      ST_MEM_READ:  state_d = ST_CAPTURE;
      ST_CAPTURE:   state_d = ST_SEND;
      ST_SEND:      state_d = tx_byte_end ? ST_DONE : ST_SEND;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_we = 1'b0;
    mem.mem_re = 1'b0;
    req_done   = 1'b0;
    send_pulse = 1'b0;
    busy       = (state_q != ST_IDLE);
    frame_err  = rx_byte_end;
    case (state_q)
      ST_IDLE:                  frame_err  = rx_byte_end && !cmd_is_legal(rx_data);
      ST_GET_ADDR, ST_GET_DATA: frame_err  = expire && !rx_byte_end;
      ST_MEM_WRITE:             mem.mem_we = (size_q[MEM_WRITE_W-1:0] != 2'b00);
      ST_MEM_READ:              mem.mem_re = 1'b1;
      ST_CAPTURE:               frame_err  = rx_byte_end;
      ST_SEND:                  send_pulse = 1'b1;
      ST_DONE:                  req_done   = 1'b1;
      default: begin
        busy      = 1'b0;
        frame_err = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_write_q <= 1'b0;
      size_q     <= 3'd0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      reply_q    <= 8'h00;
    end else begin
      if (state_q == ST_IDLE && rx_byte_end) begin
        is_write_q <= rx_data[CMD_WRITE_BIT];
        size_q     <= rx_data[SIZE_LOAD_W-1:0];
      end
      if (state_q == ST_GET_ADDR && rx_byte_end) addr_q  <= rx_data;
      if (state_q == ST_GET_DATA && rx_byte_end) wdata_q <= rx_data;
      if (state_q == ST_CAPTURE)                 reply_q <= mem.mem_rdata;
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_size  = size_q;
endmodule

// File: tb/tb_uart_mem_server.sv
// Directed bench for uart_mem_server: serial frames in, RAM model and reply decoder out.
module tb_uart_mem_server;
  localparam int CPB = 16;
  localparam int TMO = 500;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic tx, busy, req_done, frame_err;
  logic [7:0] ram [256];

  uart_mem_server_if mem_bus();

  uart_mem_server #(.TIMEOUT_CYCLES(TMO), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .mem(mem_bus),
    .busy(busy), .req_done(req_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous, read data valid the cycle after mem_re; pattern reloads on reset.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hA5;
    end else begin
      if (mem_bus.mem_we) ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
    end
    if (mem_bus.mem_re) mem_bus.mem_rdata <= ram[mem_bus.mem_addr];
  end

  int we_n = 0, re_n = 0, done_n = 0, err_n = 0, txlow_n = 0, busy_n = 0, rep_n = 0;
  logic [7:0] we_addr, we_data, re_addr, rep_byte;
  logic [2:0] we_size, re_size;
  logic       err_busy;

  always @(negedge clk) begin
    if (mem_bus.mem_we) begin
      we_n <= we_n + 1; we_addr <= mem_bus.mem_addr; we_data <= mem_bus.mem_wdata; we_size <= mem_bus.mem_size;
    end
    if (mem_bus.mem_re) begin
      re_n <= re_n + 1; re_addr <= mem_bus.mem_addr; re_size <= mem_bus.mem_size;
    end
    if (req_done) done_n <= done_n + 1;
    if (frame_err) begin err_n <= err_n + 1; err_busy <= busy; end
    if (tx === 1'b0) txlow_n <= txlow_n + 1;
    if (busy === 1'b1) busy_n <= busy_n + 1;
  end

  // Serial reply decoder: samples each bit near its centre.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = tx;
        end
        repeat (CPB) @(negedge clk);
        rep_byte = b;
        rep_n    = rep_n + 1;
      end
    end
  end

  int vectors = 0, miscompares = 0;
  int we0, re0, done0, err0, txl0, bh0, rep0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic snap();
    we0 = we_n; re0 = re_n; done0 = done_n; err0 = err_n;
    txl0 = txlow_n; bh0 = busy_n; rep0 = rep_n;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(mem_bus.mem_addr), 32'h00);
    chk("rst_wdata", 32'(mem_bus.mem_wdata), 32'h00);
    chk("rst_size", 32'(mem_bus.mem_size), 32'd0);
    chk("rst_we", 32'(mem_bus.mem_we), 32'd0);
    chk("rst_re", 32'(mem_bus.mem_re), 32'd0);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Write 0x81 0x3C 0x5A
    snap();
    send_byte(8'h81); send_byte(8'h3C); send_byte(8'h5A);
    repeat (10) @(negedge clk);
    chk("wr_we_cnt", 32'(we_n - we0), 32'd1);
    chk("wr_addr", 32'(we_addr), 32'h3C);
    chk("wr_data", 32'(we_data), 32'h5A);
    chk("wr_size", 32'(we_size), 32'd1);
    chk("wr_done_cnt", 32'(done_n - done0), 32'd1);
    chk("wr_re_cnt", 32'(re_n - re0), 32'd0);
    chk("wr_tx_low", 32'(txlow_n - txl0), 32'd0);
    chk("wr_err_cnt", 32'(err_n - err0), 32'd0);
    chk("wr_busy", 32'(busy), 32'd0);
    chk("wr_ram", 32'(ram[8'h3C]), 32'h5A);

    // Read 0x02 0x3C
    snap();
    send_byte(8'h02); send_byte(8'h3C);
    repeat (12 * CPB) @(negedge clk);
    chk("rd_re_cnt", 32'(re_n - re0), 32'd1);
    chk("rd_addr", 32'(re_addr), 32'h3C);
    chk("rd_size", 32'(re_size), 32'd2);
    chk("rd_rep_cnt", 32'(rep_n - rep0), 32'd1);
    chk("rd_reply", 32'(rep_byte), 32'h5A);
    chk("rd_done_cnt", 32'(done_n - done0), 32'd1);
    chk("rd_we_cnt", 32'(we_n - we0), 32'd0);
    chk("rd_busy", 32'(busy), 32'd0);

    // Timeout after a lone write cmd, then a good read
    snap();
    send_byte(8'h81);
    repeat (2) @(negedge clk);
    chk("to_busy_early", 32'(busy), 32'd1);
    repeat (TMO - 30) @(negedge clk);
    chk("to_busy_before", 32'(busy), 32'd1);
    chk("to_err_before", 32'(err_n - err0), 32'd0);
    repeat (50) @(negedge clk);
    chk("to_err_cnt", 32'(err_n - err0), 32'd1);
    chk("to_busy_after", 32'(busy), 32'd0);
    chk("to_strobes", 32'((we_n - we0) + (re_n - re0) + (done_n - done0)), 32'd0);
    snap();
    send_byte(8'h01); send_byte(8'h3C);
    repeat (12 * CPB) @(negedge clk);
    chk("to_rd_re_cnt", 32'(re_n - re0), 32'd1);
    chk("to_rd_size", 32'(re_size), 32'd1);
    chk("to_rd_reply", 32'(rep_byte), 32'h5A);
    chk("to_rd_done", 32'(done_n - done0), 32'd1);

    // Reserved command 0x48
    snap();
    send_byte(8'h48);
    repeat (10) @(negedge clk);
    chk("rsv_err_cnt", 32'(err_n - err0), 32'd1);
    chk("rsv_err_idle", 32'(err_busy), 32'd0);
    chk("rsv_busy_cnt", 32'(busy_n - bh0), 32'd0);
    chk("rsv_strobes", 32'((we_n - we0) + (re_n - re0) + (done_n - done0)), 32'd0);

    // Reset while the read reply is on the wire
    snap();
    send_byte(8'h02); send_byte(8'h3C);
    repeat (2 * CPB) @(negedge clk);
    for (int k = 0; k < 4 * CPB && tx !== 1'b0; k++) @(negedge clk);
    chk("rs_tx_low", 32'(tx), 32'd0);
    chk("rs_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_tx", 32'(tx), 32'd1);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_addr", 32'(mem_bus.mem_addr), 32'h00);
    reset = 1'b0;
    repeat (24 * CPB) @(negedge clk);
    chk("rs_no_done", 32'(done_n - done0), 32'd0);
    snap();
    send_byte(8'h83); send_byte(8'h10); send_byte(8'hFF);
    repeat (10) @(negedge clk);
    chk("rs_wr_we_cnt", 32'(we_n - we0), 32'd1);
    chk("rs_wr_addr", 32'(we_addr), 32'h10);
    chk("rs_wr_data", 32'(we_data), 32'hFF);
    chk("rs_wr_size", 32'(we_size), 32'd3);
    chk("rs_wr_done", 32'(done_n - done0), 32'd1);

    // Back-to-back size-0 write then read of same address
    snap();
    send_byte(8'h80); send_byte(8'h01); send_byte(8'h77);
    send_byte(8'h00); send_byte(8'h01);
    repeat (12 * CPB) @(negedge clk);
    chk("bb_we_cnt", 32'(we_n - we0), 32'd0);
    chk("bb_done_cnt", 32'(done_n - done0), 32'd2);
    chk("bb_re_cnt", 32'(re_n - re0), 32'd1);
    chk("bb_re_addr", 32'(re_addr), 32'h01);
    chk("bb_reply", 32'(rep_byte), 32'hA4);
    chk("bb_wdata", 32'(mem_bus.mem_wdata), 32'h77);
    chk("bb_size", 32'(mem_bus.mem_size), 32'd0);
    chk("bb_err_cnt", 32'(err_n - err0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_mem_server.md
# uart_mem_server

Memory-side endpoint of the serial memory link. Receives command frames from the CPU-side UART memory bridge over `rx` and decodes them into single-cycle accesses on a byte-wide synchronous memory port. For reads it returns the data byte over `tx`. It instantiates the existing `uart_sm_rx`/`uart_sm_tx` and sits between the UART pins and the data RAM.

## Interface
- `TIMEOUT_CYCLES`, default 100000: maximum idle cycles allowed between bytes of one frame. Must exceed one byte time.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `rx` in 1: serial input from the bridge.
- `tx` out 1: serial output to the bridge. Reset value 1 (line idle).
- `mem_addr` out 8: latched address. Reset 0x00.
- `mem_wdata` out 8: latched write byte. Reset 0x00.
- `mem_size` out 3: latched `cmd[2:0]`. Reset 0.
- `mem_we` out 1: write strobe, 1 cycle. Reset 0.
- `mem_re` out 1: read strobe, 1 cycle. Reset 0.
- `mem_rdata` in 8: read data, valid the cycle after `mem_re`.
- `busy` out 1: high whenever state ≠ IDLE. Reset 0.
- `req_done` out 1: one-cycle pulse when a frame completes. Reset 0.
- `frame_err` out 1: one-cycle pulse when a frame is discarded. Reset 0.

## Operation
- Frame, first byte `cmd`:
  - `cmd[7]` = 1 for write, 0 for read.
  - `cmd[6:3]` must be 0.
  - `cmd[2:0]` is the size field (SizeLoad for reads; MemWrite in `[1:0]` for writes).
- Write frame: `cmd`, `addr`, `data`. No reply byte.
- Read frame: `cmd`, `addr`. Reply: one byte, `mem_rdata`.
- States: IDLE, GET_ADDR, GET_DATA, MEM_WRITE, MEM_READ, CAPTURE, SEND, DONE.
- IDLE:
  - On `byte_end`, latch `cmd` and `mem_size`.
  - If `cmd[6:3]` ≠ 0, pulse `frame_err` and stay in IDLE.
  - Otherwise go to GET_ADDR.
- GET_ADDR: on `byte_end`, latch `mem_addr`. Go to GET_DATA for a write, MEM_READ for a read.
- GET_DATA: on `byte_end`, latch `mem_wdata`, then go to MEM_WRITE.
- MEM_WRITE:
  - `mem_we` = 1 when `mem_size[1:0]` ≠ 0.
  - A write with size 0 is a legal no-op: no strobe, but `req_done` still pulses.
  - Next state DONE.
- MEM_READ: `mem_re` = 1, then CAPTURE.
- CAPTURE: register `mem_rdata` into the reply byte, then SEND.
- SEND: `send_pulse` held high with the reply byte until `uart_sm_tx` `byte_end`, then DONE.
- DONE: `req_done` = 1, then IDLE.
- Timeout: an inter-byte counter runs in GET_ADDR and GET_DATA. It clears on entry and on every received byte. When it reaches `TIMEOUT_CYCLES-1`: pulse `frame_err` and return to IDLE. No memory access occurs.
- Bytes received in MEM_WRITE, MEM_READ, CAPTURE, SEND or DONE are dropped and pulse `frame_err`. State is unaffected.
- If a byte arrives in the same cycle the timeout fires, the byte wins and no error is raised.
- Reset at any point, including mid-transmission:
  - State returns to IDLE and all outputs take their reset values.
  - `tx` returns high immediately (via `uart_sm_tx` reset).
  - A partially received frame is lost.

## Timing
- Write: data byte's `byte_end` at cycle m → `mem_we` at m+1 → `req_done` at m+2 → IDLE at m+3.
- Read: addr byte's `byte_end` at m → `mem_re` at m+1 → reply latched at the end of m+2 → `send_pulse` from m+3.
- Read completion: `req_done` the cycle after tx `byte_end`.
- `mem_addr`, `mem_wdata` and `mem_size` are stable from latch until the next frame's corresponding byte.
- Strobes and status outputs are decoded from state. `frame_err` comes from state plus the current byte or timeout event.
- Minimum gap between frames: none. A `cmd` byte is accepted in the first IDLE cycle.

## Structure
- Shared package `mem_link_pkg`:
  - State encoding.
  - `CMD_WRITE_BIT` = 7, `CMD_RSVD_MASK` = 8'h78.
  - Size-field widths (SizeLoad 3, MemWrite 2).
- The CPU-side bridge imports the same package so both ends agree on framing.
- Instantiates the existing `uart_sm_rx` and `uart_sm_tx`.
- Sub-module `mem_link_timeout`: loadable down-counter with clear and expire pulse, sized `$clog2(TIMEOUT_CYCLES)`.

## Test plan
- Write frame 0x81, 0x3C, 0x5A → single `mem_we` with `mem_addr` 0x3C, `mem_wdata` 0x5A, `mem_size` 1; `req_done` pulse; `tx` stays high.
- Read frame 0x02, 0x3C with RAM model holding 0x5A → one `mem_re` at 0x3C, `mem_size` 2; serial reply 0x5A; then `req_done`.
- Send 0x81, then silence for `TIMEOUT_CYCLES` → `frame_err` pulse, `busy` falls, no strobe. A following valid read frame completes correctly.
- Reserved command 0x48 → `frame_err` in the byte's cycle, no strobes, state remains IDLE.
- Assert reset during SEND of a read reply → `tx` = 1 and `busy` = 0 the next cycle. A subsequent write 0x83, 0x10, 0xFF performs `mem_we` at 0x10.
- Back-to-back: write 0x80, 0x01, 0x77 (size 0), immediately followed by read 0x00, 0x01 → no `mem_we`; two `req_done` pulses; the reply equals prior RAM content.
